// File: rtl/adventure_pkg.sv
// adventure_pkg: shared types for the adventure game autoplayer.
//   dir_t      - encoded move direction as stored in the script
//   res_t      - outcome of a scripted run
//   ap_state_t - autoplayer controller states
package adventure_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'b00,
    DIR_S = 2'b01,
    DIR_E = 2'b10,
    DIR_W = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_WIN  = 2'b01,
    RES_DEAD = 2'b10
  } res_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRST   = 3'd1,
    ST_PLAY   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } ap_state_t;

endpackage

// File: rtl/dir_decoder.sv
// dir_decoder: turns an encoded direction plus enable into the game's
// one-hot direction inputs. All outputs are low when en is low.
//   dir        in  2  encoded direction (dir_t)
//   en         in  1  drive a move this cycle
//   n/s/e/w    out 1  one-hot direction strobes
module dir_decoder
  import adventure_pkg::*;
(
  input  dir_t dir,
  input  logic en,
  output logic n,
  output logic s,
  output logic e,
  output logic w
);

  // One-hot decode, all-zero when disabled
  always_comb begin
    n = 1'b0;
    s = 1'b0;
    e = 1'b0;
    w = 1'b0;
    if (en) begin
      case (dir)
        DIR_N:   n = 1'b1;
        DIR_S:   s = 1'b1;
        DIR_E:   e = 1'b1;
        DIR_W:   w = 1'b1;
        default: n = 1'b0;
      endcase
    end else begin
      n = 1'b0;
    end
  end

endmodule

// File: rtl/adventure_autoplayer.sv
// adventure_autoplayer: stores a move script and replays it into the
// adventure game, one move per cycle, then reports the outcome.
//   clk, reset         clock, async active-high reset (clears the script too)
//   load_valid/dir     script entry offer; load_ready accepts it
//   clear, start       empty the script / begin a run (IDLE or DONE only)
//   win, d             game outcome inputs (watched in PLAY/SETTLE only)
//   n/s/e/w            one-hot game direction inputs
//   game_reset         one-cycle game reset at the start of a run
//   busy, done, result run status and outcome (res_t)
//   move_count         moves issued in the current/last run
//   script_len         stored script entries
// SETTLE_CYCLES is expected to be at least 1.
module adventure_autoplayer
  import adventure_pkg::*;
#(
  parameter int MAX_MOVES     = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int CW            = $clog2(MAX_MOVES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [1:0]    load_dir,
  output logic          load_ready,
  input  logic          clear,
  input  logic          start,
  input  logic          win,
  input  logic          d,
  output logic          n,
  output logic          s,
  output logic          e,
  output logic          w,
  output logic          game_reset,
  output logic          busy,
  output logic          done,
  output logic [1:0]    result,
  output logic [CW-1:0] move_count,
  output logic [CW-1:0] script_len
);

  localparam int IW = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  ap_state_t     state_r;
  dir_t          script_r [MAX_MOVES];
  logic [CW-1:0] script_len_r;
  logic [CW-1:0] move_count_r;
  logic [CW-1:0] idx_r;
  logic [SW-1:0] settle_cnt_r;
  res_t          result_r;
  logic          done_r;
  logic          ctrl_s;
  logic          play_s;

  assign ctrl_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign play_s = (state_r == ST_PLAY);

  assign load_ready = ctrl_s && (script_len_r < CW'(MAX_MOVES));
  assign game_reset = (state_r == ST_GRST);
  assign busy       = (state_r == ST_GRST) || play_s || (state_r == ST_SETTLE);
  assign done       = done_r;
  assign result     = result_r;
  assign move_count = move_count_r;
  assign script_len = script_len_r;

  // Direction strobes depend only on registered state and index
  dir_decoder u_dec (
    .dir (script_r[idx_r[IW-1:0]]),
    .en  (play_s),
    .n   (n),
    .s   (s),
    .e   (e),
    .w   (w)
  );

  // Controller FSM, script storage and run status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      script_len_r <= '0;
      move_count_r <= '0;
      idx_r        <= '0;
      settle_cnt_r <= '0;
      result_r     <= RES_NONE;
      done_r       <= 1'b0;
      for (int i = 0; i < MAX_MOVES; i++) begin
        script_r[i] <= DIR_N;
      end
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (clear) begin
            // clear takes priority over any load or start this cycle
            state_r      <= ST_IDLE;
            script_len_r <= '0;
            done_r       <= 1'b0;
            result_r     <= RES_NONE;
          end else begin
            if (load_valid && load_ready) begin
              script_r[script_len_r[IW-1:0]] <= dir_t'(load_dir);
              script_len_r <= script_len_r + CW'(1);
            end
            if (start) begin
              move_count_r <= '0;
              result_r     <= RES_NONE;
              if (script_len_r == '0) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end else begin
                state_r <= ST_GRST;
                done_r  <= 1'b0;
              end
            end
          end
        end
        ST_GRST: begin
          idx_r   <= '0;
          state_r <= ST_PLAY;
        end
        ST_PLAY: begin
          if (win) begin
            state_r  <= ST_DONE;
            result_r <= RES_WIN;
            done_r   <= 1'b1;
          end else if (d) begin
            state_r  <= ST_DONE;
            result_r <= RES_DEAD;
            done_r   <= 1'b1;
          end else begin
            move_count_r <= move_count_r + CW'(1);
            if (idx_r == script_len_r - CW'(1)) begin
              state_r      <= ST_SETTLE;
              settle_cnt_r <= '0;
            end else begin
              idx_r <= idx_r + CW'(1);
            end
          end
        end
        ST_SETTLE: begin
          if (win) begin
            state_r  <= ST_DONE;
            result_r <= RES_WIN;
            done_r   <= 1'b1;
          end else if (d) begin
            state_r  <= ST_DONE;
            result_r <= RES_DEAD;
            done_r   <= 1'b1;
          end else if (settle_cnt_r == SW'(SETTLE_CYCLES - 1)) begin
            state_r  <= ST_DONE;
            result_r <= RES_NONE;
            done_r   <= 1'b1;
          end else begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adventure_autoplayer.sv
// Bench for adventure_autoplayer: a scoreboard queue holds the expected
// one-hot moves of each run; the bench plays the game by raising win/d
// at chosen cycles of the run.
module tb_adventure_autoplayer;

  localparam int MAX = 16;
  localparam int SET = 2;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid, load_ready, clear, start, win, d;
  logic [1:0]    load_dir, result;
  logic          n, s, e, w, game_reset, busy, done;
  logic [CW-1:0] move_count, script_len;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic [1:0] model_script[MAX];
  int         model_len = 0;

  adventure_autoplayer #(.MAX_MOVES(MAX), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_dir(load_dir),
    .load_ready(load_ready), .clear(clear), .start(start), .win(win), .d(d),
    .n(n), .s(s), .e(e), .w(w), .game_reset(game_reset), .busy(busy),
    .done(done), .result(result), .move_count(move_count), .script_len(script_len)
  );

  always #5 clk = ~clk;

  // {n,s,e,w} expected for a stored direction
  function automatic logic [3:0] onehot(input logic [1:0] dd);
    case (dd)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_len = 0;
    checks++;
    if ({script_len, done, result} !== {CW'(0), 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL clear: len=%0d done=%b result=%0d required 0/0/0", script_len, done, result);
    end
  endtask

  task automatic load_dirs(input logic [1:0] dl[$]);
    foreach (dl[i]) begin
      load_valid = 1'b1;
      load_dir = dl[i];
      checks++;
      if (load_ready !== (model_len < MAX)) begin
        failures++;
        $display("FAIL load_ready: entry %0d got %b required %b", i, load_ready, (model_len < MAX));
      end
      @(negedge clk);
      if (model_len < MAX) begin
        model_script[model_len] = dl[i];
        model_len++;
      end
    end
    load_valid = 1'b0;
    checks++;
    if (script_len !== CW'(model_len)) begin
      failures++;
      $display("FAIL script_len: got %0d required %0d", script_len, model_len);
    end
  endtask

  // kind: 0 none, 1 win, 2 dead, 3 win+dead, raised for sampling at end of cycle term_c
  task automatic run_script(input int term_c, input int kind, input logic [1:0] exp_res);
    int exp_mc, done_c, nmoves, c;
    bit finished;
    logic [3:0] obs, expv;
    if (kind == 0) begin
      exp_mc = model_len;
      nmoves = model_len;
      done_c = 1 + model_len + SET;
    end else begin
      exp_mc = (term_c - 1 < model_len) ? term_c - 1 : model_len;
      nmoves = (term_c < model_len) ? term_c : model_len;
      done_c = term_c + 1;
    end
    for (int i = 0; i < nmoves; i++) exp_q.push_back(onehot(model_script[i]));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    checks++;
    if ({game_reset, n, s, e, w, busy, done} !== 7'b1000010) begin
      failures++;
      $display("FAIL grst: got grst=%b dirs=%b%b%b%b busy=%b done=%b required 1/0000/1/0",
               game_reset, n, s, e, w, busy, done);
    end
    finished = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (c == term_c && kind != 0) begin
        win = (kind == 1 || kind == 3);
        d   = (kind == 2 || kind == 3);
      end
      @(negedge clk);
      win = 1'b0;
      d = 1'b0;
      c++;
      obs = {n, s, e, w};
      if (obs !== 4'b0000 || game_reset !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0 || game_reset !== 1'b0) begin
          failures++;
          $display("FAIL move: cycle %0d got dirs=%b grst=%b required no move", c, obs, game_reset);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            failures++;
            $display("FAIL move: cycle %0d got %b required %b", c, obs, expv);
          end
        end
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    checks++;
    if (!finished || c != done_c) begin
      failures++;
      $display("FAIL done_time: finished=%b cycle %0d required %0d", finished, c, done_c);
    end
    checks++;
    if (result !== exp_res || move_count !== CW'(exp_mc) || busy !== 1'b0) begin
      failures++;
      $display("FAIL outcome: result=%0d moves=%0d busy=%b required %0d/%0d/0",
               result, move_count, busy, exp_res, exp_mc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL moves_missing: %0d expected moves never driven", exp_q.size());
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || result !== exp_res || move_count !== CW'(exp_mc)) begin
      failures++;
      $display("FAIL done_hold: done=%b result=%0d moves=%0d required 1/%0d/%0d",
               done, result, move_count, exp_res, exp_mc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b0; load_dir = 2'd0; clear = 1'b0; start = 1'b0; win = 1'b0; d = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({n, s, e, w, game_reset, busy, done, result} !== 9'b0 ||
        move_count !== '0 || script_len !== '0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: dirs=%b%b%b%b grst=%b busy=%b done=%b res=%0d mc=%0d len=%0d rdy=%b",
               n, s, e, w, game_reset, busy, done, result, move_count, script_len, load_ready);
    end
  endtask

  task automatic test_dead();
    load_dirs('{2'd2, 2'd1, 2'd2});
    run_script(4, 2, 2'b10);
  endtask

  task automatic test_win();
    do_clear();
    load_dirs('{2'd2, 2'd1, 2'd3, 2'd2, 2'd2});
    run_script(6, 1, 2'b01);
  endtask

  task automatic test_settle();
    do_clear();
    load_dirs('{2'd2});
    run_script(0, 0, 2'b00);
  endtask

  task automatic test_early_terminate();
    do_clear();
    load_dirs('{2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
    run_script(2, 2, 2'b10);
    run_script(3, 3, 2'b01);
  endtask

  task automatic test_back_to_back_full();
    logic [1:0] dl[$];
    do_clear();
    for (int i = 0; i < MAX + 1; i++) dl.push_back(2'($urandom_range(0, 3)));
    load_dirs(dl);
    checks++;
    if (load_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: got %b required 0", load_ready);
    end
    run_script(0, 0, 2'b00);
  endtask

  task automatic test_empty_start();
    do_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 2'b00 || move_count !== '0 || game_reset !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_start: done=%b res=%0d mc=%0d grst=%b busy=%b required 1/0/0/0/0",
               done, result, move_count, game_reset, busy);
    end
  endtask

  task automatic test_midrun_reset();
    do_clear();
    load_dirs('{2'd2, 2'd1, 2'd2, 2'd3});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    load_valid = 1'b1; load_dir = 2'd3; clear = 1'b1; start = 1'b1;
    checks++;
    if (load_ready !== 1'b0) begin
      failures++;
      $display("FAIL play_ready: got %b required 0", load_ready);
    end
    @(negedge clk);
    load_valid = 1'b0; clear = 1'b0; start = 1'b0;
    checks++;
    if ({n, s, e, w} !== 4'b0100 || script_len !== CW'(4) || busy !== 1'b1) begin
      failures++;
      $display("FAIL play_ignore: dirs=%b len=%0d busy=%b required 0100/4/1", {n, s, e, w}, script_len, busy);
    end
    @(negedge clk);
    checks++;
    if ({n, s, e, w} !== 4'b0010) begin
      failures++;
      $display("FAIL move2: got %b required 0010", {n, s, e, w});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({n, s, e, w, game_reset, busy, done, result} !== 9'b0 ||
        move_count !== '0 || script_len !== '0) begin
      failures++;
      $display("FAIL midrun_reset: dirs=%b%b%b%b grst=%b busy=%b done=%b mc=%0d len=%0d required all 0",
               n, s, e, w, game_reset, busy, done, move_count, script_len);
    end
    @(negedge clk);
    reset = 1'b0;
    model_len = 0;
    @(negedge clk);
  endtask

  task automatic test_clear_start();
    load_dirs('{2'd0, 2'd1});
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    model_len = 0;
    checks++;
    if (script_len !== '0 || busy !== 1'b0 || game_reset !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL clear_start: len=%0d busy=%b grst=%b done=%b required 0/0/0/0",
               script_len, busy, game_reset, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || {n, s, e, w} !== 4'b0000) begin
      failures++;
      $display("FAIL clear_start_idle: busy=%b dirs=%b required 0/0000", busy, {n, s, e, w});
    end
  endtask

  initial begin
    test_reset();
    test_dead();
    test_win();
    test_settle();
    test_early_terminate();
    test_back_to_back_full();
    test_empty_start();
    test_midrun_reset();
    test_clear_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adventure_autoplayer.md
# adventure_autoplayer

Scripted player for the lab 3 adventure game. It stores a short move script through a valid/ready load port. On `start` it resets the game and drives the one-hot `n`/`s`/`e`/`w` inputs one move per cycle. It watches the game's `win`/`d` outputs and reports the outcome and the number of moves issued. It sits between the board-level controls (or a bench) and the game, in place of the hand-driven direction switches.

## Interface
Parameters:
- `MAX_MOVES`, default 16: script capacity in moves.
- `SETTLE_CYCLES`, default 2: idle cycles after the last move in which `win`/`d` are still checked.

Ports (`CW` = `$clog2(MAX_MOVES+1)`):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state including the script.
- `load_valid`  in  1  script entry offered.
- `load_dir`  in  2  direction of the offered entry (`dir_t`).
- `load_ready`  out  1  entry accepted when `load_valid & load_ready`.
- `clear`  in  1  empties the script (IDLE/DONE only).
- `start`  in  1  begins a run.
- `win`  in  1  game win output.
- `d`  in  1  game dead output.
- `n`, `s`, `e`, `w`  out  1 each  game direction inputs; at most one is high.
- `game_reset`  out  1  game reset.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until the next `start` or `clear`.
- `result`  out  2  `res_t` outcome of the last run.
- `move_count`  out  CW  moves issued in the last or current run.
- `script_len`  out  CW  stored entries.

## Operation
- States: IDLE, GRST, PLAY, SETTLE, DONE.
- Reset values: state=IDLE, `script_len`=0, `move_count`=0, `result`=NONE, `n`/`s`/`e`/`w`/`game_reset`/`busy`/`done`=0.
- **IDLE/DONE:**
  - `load_ready`=(`script_len`<MAX_MOVES).
  - An accepted entry is written at index `script_len`, then `script_len` increments.
  - When full, `load_ready`=0 and offered entries are dropped without error.
  - `clear` sets `script_len`=0, `done`=0, `result`=NONE. `clear` wins over a simultaneous load or start.
  - `start` with `script_len`=0 goes straight to DONE with `result`=NONE and `move_count`=0.
  - `start` with `script_len`>0 goes to GRST: clears `move_count`, `done` and `result`.
- **GRST:** one cycle; `game_reset`=1, all directions 0. Next state PLAY with idx=0.
- **PLAY:**
  - Direction outputs decode `script[idx]`; `busy`=1; `load_ready`=0.
  - On each edge, if `win`: DONE, `result`=WIN.
  - Else if `d`: DONE, `result`=DEAD.
  - Else `move_count`++ and idx++. When idx reaches `script_len`-1, go to SETTLE.
  - A move driven in the cycle that terminates is not counted.
- **SETTLE:** directions 0. Up to SETTLE_CYCLES cycles checking `win` then `d` as in PLAY. On expiry go to DONE with `result`=NONE.
- **Signal rules:** `start`, `load_valid` and `clear` are ignored outside IDLE/DONE. `win` and `d` are ignored outside PLAY/SETTLE.
- **Mid-run reset:** asynchronous return to reset values. The script is lost.

## Timing
- Start to first move: `start` is high at edge T; `game_reset` is high in cycle T..T+1; move 0 is driven in cycle T+1..T+2.
- Moves are issued back to back, one per cycle, with no gaps.
- Outcome latency: `win`/`d` sampled high at edge E gives `done`=1 and final `result` from E onward. `move_count` is stable at the same time.
- `n`/`s`/`e`/`w`/`game_reset` are decoded combinationally from registered state and idx only; no combinational path from any input.
- Minimum run length: 1 + `script_len` + SETTLE_CYCLES cycles when there is no early termination.

## Structure
- Package `adventure_pkg` holds:
  - `dir_t`: N=2'b00, S=2'b01, E=2'b10, W=2'b11.
  - `res_t`: NONE=2'b00, WIN=2'b01, DEAD=2'b10.
  - `ap_state_t` enum.
- Sub-module `dir_decoder`: `dir_t` plus enable to one-hot `n`/`s`/`e`/`w`.
- The script is a register array in the top module; no RAM macro.

## Test plan
Benches run against the lab 3 adventure game.
- Load E,S,E; `start` → `game_reset` pulse, then E,S,E on consecutive cycles. `d` rises; `result`=DEAD, `move_count`=3.
- Load E,S,W,E,E; `start` → `result`=WIN, `move_count`=5, `done` held until next `start`.
- Load E only; `start` → no terminal, SETTLE expires 2 cycles after the move. `result`=NONE, `move_count`=1.
- Offer 17 entries with MAX_MOVES=16 → `load_ready` drops after 16, `script_len`=16. `start` with `script_len`=0 → immediate DONE, NONE.
- Assert `reset` during PLAY move 2 → all outputs 0 immediately, `script_len`=0. `load_valid`/`start` during PLAY are ignored.
- `clear` and `start` in the same IDLE cycle → `clear` wins: `script_len`=0, no run starts.
